// File: rtl/alu_seq_ctrl.sv
// Multi-byte ALU sequencer: runs a W-bit add/sub/AND/OR one byte per cycle
// (LSB first) through an external shared 8-bit ALU, with valid/ready handshakes.
module alu_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_data,
  output logic                  rsp_cout,
  output logic                  rsp_zero,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  output logic [1:0]            alu_sel,
  input  logic [7:0]            alu_out,
  input  logic                  alu_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_p0;
  logic [W-1:0]    b_p0;
  logic [1:0]      op_p0;
  logic            carry_p0;
  logic [IW-1:0]   idx_p0;
  logic [W-1:0]    result_p1;
  logic            cout_p1;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;

  // Carry/borrow only chains for arithmetic ops; logic ops force it to 0.
  function automatic logic carry_mask(input logic [1:0] op, input logic c);
    return (op[1] == 1'b0) ? c : 1'b0;
  endfunction

  // Stage p0: operand capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      a_p0  <= req_a;
      b_p0  <= req_b;
      op_p0 <= req_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry_p0  <= 1'b0;
      idx_p0    <= '0;
      result_p1 <= '0;
      cout_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= RUN;
            idx_p0   <= '0;
            carry_p0 <= carry_mask(req_op, req_cin);
          end
        end
        RUN: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (idx_p0 == IW'(k)) result_p1[8*k +: 8] <= alu_out;
          end
          carry_p0 <= carry_mask(op_p0, alu_cout);
          if (idx_p0 == LAST) begin
            idx_p0  <= '0;
            cout_p1 <= carry_mask(op_p0, alu_cout);
            state   <= DONE;
          end else begin
            idx_p0 <= idx_p0 + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: byte slice select toward the shared ALU
  assign a_sh = a_p0 >> {idx_p0, 3'b000};
  assign b_sh = b_p0 >> {idx_p0, 3'b000};

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sel = '0;
    if (state == RUN) begin
      alu_a   = a_sh[7:0];
      alu_b   = b_sh[7:0];
      alu_cin = carry_p0;
      alu_sel = op_p0;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_data  = result_p1;
  assign rsp_cout  = cout_p1;
  assign rsp_zero  = (result_p1 == '0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (NBYTES=4) with a reference 8-bit ALU on the alu_* ports.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_cin;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_zero;
  logic [31:0] rsp_data;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_cin, alu_cout;
  logic [1:0]  alu_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // Reference shared ALU
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_sel)
      2'b00: alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      2'b01: alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      2'b10: alu_wide = {1'b0, alu_a & alu_b};
      default: alu_wide = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_out  = alu_wide[7:0];
  assign alu_cout = alu_wide[8];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_data;
    logic        exp_cout;
    int          exp_cin_ones;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one request at a negedge, accept at the next posedge, then wait for rsp_valid.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output int k, output int ones);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = a ^ b; req_cin = ~cin;
    k = 0; ones = 0;
    while (!rsp_valid && k < 20) begin
      if (alu_cin) ones++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {63'd0, rsp_valid}, 64'd0);
    chk("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int k, ones;
    logic [31:0] held;

    vecs[0] = '{2'b00, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, -1};
    vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4};
    vecs[2] = '{2'b01, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1};
    vecs[3] = '{2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 3};
    vecs[4] = '{2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0, 0};
    vecs[5] = '{2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hFFF0FFF0, 1'b0, 0};
    vecs[6] = '{2'b00, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 0};
    vecs[7] = '{2'b01, 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 4};
    vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_cin = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_rsp_zero", {63'd0, rsp_zero}, 64'd1);
    chk("rst_rsp_cout", {63'd0, rsp_cout}, 64'd0);
    chk("rst_alu_idle", {44'd0, alu_a, alu_b, alu_cin, alu_sel}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, k, ones);
      chk("latency", 64'(k), 64'd4);
      chk("rsp_data", {32'd0, rsp_data}, {32'd0, vecs[i].exp_data});
      chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, vecs[i].exp_cout});
      chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, (vecs[i].exp_data == 32'd0)});
      chk("alu_done_zero", {44'd0, alu_a, alu_b, alu_cin, alu_sel}, 64'd0);
      if (vecs[i].exp_cin_ones >= 0) chk("alu_cin_ones", 64'(ones), 64'(vecs[i].exp_cin_ones));
      finish_rsp();
    end

    // Back-pressure in DONE with a competing request offered
    do_req(2'b00, 32'h00000001, 32'h00000002, 1'b0, k, ones);
    chk("bp_latency", 64'(k), 64'd4);
    held = rsp_data;
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'hDEADBEEF; req_b = 32'h01010101; req_cin = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_rsp_data", {32'd0, rsp_data}, 64'h3);
      chk("bp_rsp_held", {32'd0, rsp_data}, {32'd0, held});
      chk("bp_rsp_cout", {63'd0, rsp_cout}, 64'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    chk("bp_no_capture", {63'd0, req_ready}, 64'd1);

    // Reset while RUN is on slice 2
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h01020304; req_b = 32'h10203040; req_cin = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_run_busy", {63'd0, req_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_data", {32'd0, rsp_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {62'd0, rsp_valid, req_ready}, 64'd1);
    end
    do_req(2'b00, 32'h01020304, 32'h10203040, 1'b0, k, ones);
    chk("post_rst_latency", 64'(k), 64'd4);
    chk("post_rst_data", {32'd0, rsp_data}, 64'h11223344);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, number of 8-bit slices per operation (W = 8*NBYTES).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
REQ-007 req_op  in  2  00 add, 01 subtract (a-b-borrow), 10 AND, 11 OR.
REQ-008 req_a, req_b  in  W  operands.
REQ-009 req_cin  in  1  carry-in (add) / borrow-in (sub); ignored for AND/OR.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  result consumed when rsp_valid & rsp_ready at a rising edge.
REQ-012 rsp_data  out  W  result word.
REQ-013 rsp_cout  out  1  final carry-out (add) / borrow-out (sub); 0 for AND/OR.
REQ-014 rsp_zero  out  1  1 when rsp_data == 0.
REQ-015 alu_a, alu_b  out  8  byte operands to the shared 8-bit ALU.
REQ-016 alu_cin  out  1  ALU carry/borrow-in.
REQ-017 alu_sel  out  2  ALU operation select, same encoding as req_op.
REQ-018 alu_out  in  8  ALU result (combinational from alu_* outputs).
REQ-019 alu_cout  in  1  ALU carry/borrow-out.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE.
REQ-021 IDLE: req_ready=1; on handshake capture req_a, req_b, req_op, carry=req_cin for op 00/01 else 0, slice index=0, go RUN.
REQ-022 RUN: req_ready=0; drive alu_a=a[8i+7:8i], alu_b=b[8i+7:8i], alu_cin=carry, alu_sel=op for slice i.
REQ-023 RUN each edge: result[8i+7:8i]<=alu_out; carry<=alu_cout for op 00/01, 0 for op 10/11; i<=i+1.
REQ-024 RUN with i==NBYTES-1: after the store, go DONE; rsp_cout<=final carry.
REQ-025 DONE: rsp_valid=1; rsp_data, rsp_cout, rsp_zero held stable until rsp handshake, then IDLE.
REQ-026 Latency: handshake at edge E0 -> rsp_valid high after edge E0+NBYTES; slice order LSB first.
REQ-027 req_ready SHALL be 0 in RUN and DONE; req_valid there is ignored and nothing is captured.
REQ-028 In IDLE and DONE, alu_a, alu_b, alu_cin, alu_sel SHALL be driven 0.
REQ-029 Slice index SHALL be ceil(log2(NBYTES)) bits minimum and never address beyond NBYTES-1.
REQ-030 Operand changes on req_* after acceptance SHALL not affect the running operation.
REQ-031 rsp_ready high outside DONE SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_data=0, rsp_cout=0, slice index=0, carry=0.
REQ-033 rsp_zero SHALL read 1 in reset (rsp_data=0); req_ready SHALL read 1 during and after reset.
REQ-034 Reset mid-RUN or mid-DONE SHALL discard the operation; no response emitted after release.

Verification (NBYTES=4, reference 8-bit ALU model attached to alu_* ports)
REQ-035 add 0x000000FF+0x00000001 cin=0 -> rsp_data 0x00000100, cout 0, rsp_valid 4 cycles after accept.
REQ-036 add 0xFFFFFFFF+0x00000000 cin=1 -> rsp_data 0x00000000, cout 1, zero 1; alu_cin=1 in all 4 RUN cycles.
REQ-037 sub 0x00000100-0x00000001 bin=0 -> 0x000000FF, cout 0; sub 0x00000000-0x00000001 -> 0xFFFFFFFF, cout 1.
REQ-038 AND 0xF0F0F0F0,0xFF00FF00 cin=1 -> 0xF000F000, cout 0, alu_cin 0 every cycle; OR same operands -> 0xFFF0FFF0.
REQ-039 rsp_ready held 0 for 5 cycles in DONE with req_valid=1 -> rsp_* stable, req_ready 0, no capture; then one handshake, IDLE.
REQ-040 rst_n low during RUN slice 2 -> rsp_valid 0 at once, req_ready 1 after release, no rsp_valid until next request completes.
